// File: rtl/jk_fsm_bank.sv
// Bank of N independent two-state ON/OFF channels with JK or set-priority SR
// transition rules, per-channel post-transition lockout and edge pulses.
module jk_fsm_bank #(
  parameter int unsigned N    = 4,
  parameter int unsigned HOLD = 2,
  parameter int unsigned MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [N-1:0]               j,
  input  logic [N-1:0]               k,
  output logic [N-1:0]               out,
  output logic [N-1:0]               rise,
  output logic [N-1:0]               fall,
  output logic [N-1:0]               locked,
  output logic [$clog2(N+1)-1:0]     on_count
);

  localparam int unsigned CNTW = $clog2(N + 1);

  typedef enum logic {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } state_t;

  state_t          r_state [N];
  state_t          w_state [N];
  logic [N-1:0]    w_tr;
  logic [N-1:0]    w_rise;
  logic [N-1:0]    w_fall;
  logic [N-1:0]    w_locked;
  logic [N-1:0]    r_rise;
  logic [N-1:0]    r_fall;
  logic [CNTW-1:0] w_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) r_state[i] <= S_OFF;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) r_state[i] <= w_state[i];
      r_rise <= w_rise;
      r_fall <= w_fall;
    end
  end

  always_comb begin
    w_tr   = '0;
    w_rise = '0;
    w_fall = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_state[i] = r_state[i];
      if (en && !w_locked[i]) begin
        unique case (r_state[i])
          S_OFF: if (j[i]) w_state[i] = S_ON;
          S_ON: begin
            // MODE 1 gives j priority, so j&k keeps an ON channel ON
            if (MODE == 0) begin
              if (k[i]) w_state[i] = S_OFF;
            end else begin
              if (k[i] && !j[i]) w_state[i] = S_OFF;
            end
          end
          default: w_state[i] = S_OFF;
        endcase
      end
      w_tr[i]   = (w_state[i] != r_state[i]);
      w_rise[i] = w_tr[i] && (w_state[i] == S_ON);
      w_fall[i] = w_tr[i] && (w_state[i] == S_OFF);
    end
  end

  generate
    if (HOLD > 0) begin : g_hold
      localparam int unsigned HW = $clog2(HOLD + 1);
      logic [HW-1:0] r_hold [N];

      // Counter runs regardless of en so lockout always expires
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < N; i++) r_hold[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < N; i++) begin
            if (w_tr[i])
              r_hold[i] <= HW'(HOLD);
            else if (r_hold[i] != '0)
              r_hold[i] <= r_hold[i] - HW'(1);
          end
        end
      end

      always_comb begin
        w_locked = '0;
        for (int unsigned i = 0; i < N; i++) w_locked[i] = (r_hold[i] != '0);
      end
    end else begin : g_nohold
      assign w_locked = '0;
    end
  endgenerate

  always_comb begin
    out   = '0;
    w_cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      out[i] = (r_state[i] == S_ON);
      w_cnt  = w_cnt + CNTW'(out[i]);
    end
  end

  assign rise     = r_rise;
  assign fall     = r_fall;
  assign locked   = w_locked;
  assign on_count = w_cnt;

endmodule

// File: tb/tb_jk_fsm_bank.sv
// Self-checking bench: three builds (JK/HOLD=2, SR/HOLD=2, JK/HOLD=0) share stimulus
// and are each compared every cycle against a rule-level reference model.
module tb_jk_fsm_bank;

  localparam int NC = 3;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic [3:0] j, k;
  logic [NC-1:0][3:0] d_out, d_rise, d_fall, d_locked;
  logic [NC-1:0][2:0] d_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_fsm_bank #(.N(4), .HOLD(2), .MODE(0)) u_jk (
    .clk(clk), .reset(reset), .en(en), .j(j), .k(k),
    .out(d_out[0]), .rise(d_rise[0]), .fall(d_fall[0]),
    .locked(d_locked[0]), .on_count(d_cnt[0]));

  jk_fsm_bank #(.N(4), .HOLD(2), .MODE(1)) u_sr (
    .clk(clk), .reset(reset), .en(en), .j(j), .k(k),
    .out(d_out[1]), .rise(d_rise[1]), .fall(d_fall[1]),
    .locked(d_locked[1]), .on_count(d_cnt[1]));

  jk_fsm_bank #(.N(4), .HOLD(0), .MODE(0)) u_h0 (
    .clk(clk), .reset(reset), .en(en), .j(j), .k(k),
    .out(d_out[2]), .rise(d_rise[2]), .fall(d_fall[2]),
    .locked(d_locked[2]), .on_count(d_cnt[2]));

  // Reference model: per build, per channel ON flag and cycles of lockout left
  int cfg_mode [NC] = '{0, 1, 0};
  int cfg_hold [NC] = '{2, 2, 0};
  bit m_on   [NC][4];
  int m_lock [NC][4];
  bit m_rise [NC][4];
  bit m_fall [NC][4];

  function automatic void model_reset();
    for (int d = 0; d < NC; d++)
      for (int i = 0; i < 4; i++) begin
        m_on[d][i] = 0; m_lock[d][i] = 0; m_rise[d][i] = 0; m_fall[d][i] = 0;
      end
  endfunction

  function automatic void model_edge();
    bit nxt, changed;
    for (int d = 0; d < NC; d++)
      for (int i = 0; i < 4; i++) begin
        nxt = m_on[d][i];
        if (en && m_lock[d][i] == 0) begin
          if (cfg_mode[d] == 0) begin
            if (!m_on[d][i]) nxt = j[i];
            else             nxt = !k[i];
          end else begin
            if (j[i])      nxt = 1;
            else if (k[i]) nxt = 0;
          end
        end
        changed = (nxt != m_on[d][i]);
        m_rise[d][i] = changed && nxt;
        m_fall[d][i] = changed && !nxt;
        m_on[d][i] = nxt;
        if (changed)               m_lock[d][i] = cfg_hold[d];
        else if (m_lock[d][i] > 0) m_lock[d][i] = m_lock[d][i] - 1;
      end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] eo, er, ef, el;
    int cnt;
    for (int d = 0; d < NC; d++) begin
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        eo[i] = m_on[d][i]; er[i] = m_rise[d][i]; ef[i] = m_fall[d][i];
        el[i] = (m_lock[d][i] != 0);
        cnt += int'(m_on[d][i]);
      end
      chk($sformatf("cfg%0d out", d),      32'(d_out[d]),    32'(eo));
      chk($sformatf("cfg%0d rise", d),     32'(d_rise[d]),   32'(er));
      chk($sformatf("cfg%0d fall", d),     32'(d_fall[d]),   32'(ef));
      chk($sformatf("cfg%0d locked", d),   32'(d_locked[d]), 32'(el));
      chk($sformatf("cfg%0d on_count", d), 32'(d_cnt[d]),    32'(cnt));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] j, k;
    logic [3:0] out, rise, fall, locked;
    int         cnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic e, logic [3:0] jj, logic [3:0] kk, logic [3:0] o,
                              logic [3:0] r, logic [3:0] f, logic [3:0] l, int c);
    vec_t v;
    v.en = e; v.j = jj; v.k = kk; v.out = o; v.rise = r; v.fall = f; v.locked = l; v.cnt = c;
    return v;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; j = '0; k = '0;
    model_reset();

    //            en  j        k        out      rise     fall     locked   cnt
    tbl[0]  = mk(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1);
    tbl[1]  = mk(1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1);
    tbl[2]  = mk(1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
    tbl[3]  = mk(1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 0);
    tbl[4]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0);
    tbl[5]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[6]  = mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4);
    tbl[7]  = mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4);
    tbl[8]  = mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4);
    tbl[9]  = mk(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 0);
    tbl[10] = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0);
    tbl[11] = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[12] = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[13] = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[14] = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[15] = mk(1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4);

    do_reset();

    for (int n = 0; n < 16; n++) begin
      en = tbl[n].en; j = tbl[n].j; k = tbl[n].k;
      step();
      chk($sformatf("tbl%0d out", n),    32'(d_out[0]),    32'(tbl[n].out));
      chk($sformatf("tbl%0d rise", n),   32'(d_rise[0]),   32'(tbl[n].rise));
      chk($sformatf("tbl%0d fall", n),   32'(d_fall[0]),   32'(tbl[n].fall));
      chk($sformatf("tbl%0d locked", n), 32'(d_locked[0]), 32'(tbl[n].locked));
      chk($sformatf("tbl%0d cnt", n),    32'(d_cnt[0]),    32'(tbl[n].cnt));
    end

    // Asynchronous reset mid-lockout, held across an edge with active requests
    reset = 1'b1;
    model_reset();
    #2;
    chk("async rst out",    32'(d_out[0]),    32'h0);
    chk("async rst locked", 32'(d_locked[0]), 32'h0);
    chk("async rst cnt",    32'(d_cnt[0]),    32'h0);
    chk("async rst rise",   32'(d_rise[0]),   32'h0);
    en = 1'b1; j = 4'b1111; k = 4'b0000;
    step();
    chk("rst hold out", 32'(d_out[0]), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    j = 4'b0001;
    step();
    chk("post rst out",    32'(d_out[0]),    32'h1);
    chk("post rst rise",   32'(d_rise[0]),   32'h1);
    chk("post rst locked", 32'(d_locked[0]), 32'h1);
    chk("post rst cnt",    32'(d_cnt[0]),    32'h1);

    // Set-priority build: j&k keeps ON channels ON, k alone clears
    do_reset();
    en = 1'b1; j = 4'b1111; k = 4'b0000;
    step();
    j = 4'b0000;
    step();
    step();
    j = 4'b1111; k = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("sr jk%0d out", c),    32'(d_out[1]),                 32'hF);
      chk($sformatf("sr jk%0d pulses", c), 32'({d_rise[1], d_fall[1]}),   32'h0);
      chk($sformatf("sr jk%0d locked", c), 32'(d_locked[1]),              32'h0);
    end
    j = 4'b0000; k = 4'b0101;
    step();
    chk("sr clear out", 32'(d_out[1]), 32'hA);
    chk("sr clear cnt", 32'(d_cnt[1]), 32'd2);

    // No-lockout build: channel 2 follows alternating j/k every edge
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      j = (c % 2 == 0) ? 4'b0100 : 4'b0000;
      k = (c % 2 == 0) ? 4'b0000 : 4'b0100;
      step();
      chk($sformatf("h0 toggle%0d", c), 32'(d_out[2][2]), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("h0 locked%0d", c), 32'(d_locked[2]), 32'h0);
    end

    // Randomized traffic with occasional asynchronous resets
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) != 0);
      j  = 4'($urandom);
      k  = 4'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        model_reset();
        #2;
        compare_all();
        step();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_fsm_bank.md
JK_FSM_BANK -- requirements
Module: jk_fsm_bank

Interface
REQ-001 Parameter N, default 4, number of independent ON/OFF channels (1..32).
REQ-002 Parameter HOLD, default 2, lockout cycles after each channel transition (0..15; 0 disables lockout).
REQ-003 Parameter MODE, default 0, transition rule: 0 = JK (j&k toggles), 1 = SR set-priority (j&k forces ON).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  global update enable; when 0 no channel changes state.
REQ-007 j  input  N  per-channel turn-on request.
REQ-008 k  input  N  per-channel turn-off request.
REQ-009 out  output  N  registered per-channel state, 1 = ON, 0 = OFF.
REQ-010 rise  output  N  registered one-cycle pulse, high in the cycle out[i] first reads 1 after an OFF->ON transition.
REQ-011 fall  output  N  registered one-cycle pulse, high in the cycle out[i] first reads 0 after an ON->OFF transition.
REQ-012 locked  output  N  per-channel lockout status, 1 while the channel's hold counter is nonzero.
REQ-013 on_count  output  clog2(N+1)  population count of out, combinational from the out registers, no added latency.

Function
REQ-014 Each channel shall be a two-state Moore FSM, states OFF (out=0) and ON (out=1), with its own hold counter of width clog2(HOLD+1) (HOLD=0: no counter, locked tied 0).
REQ-015 A channel shall be eligible at an edge iff en=1 and locked[i]=0; an ineligible channel holds out[i].
REQ-016 MODE 0, eligible: OFF with j=1 -> ON; OFF with j=0 -> OFF; ON with k=1 -> OFF; ON with k=0 -> ON (j=k=1 therefore toggles).
REQ-017 MODE 1, eligible: OFF with j=1 -> ON; ON with k=1 and j=0 -> OFF; ON with j=1 -> ON regardless of k; all other cases hold.
REQ-018 Next-state latency shall be one clock: inputs sampled at edge t appear on out at edge t.
REQ-019 On each transition of channel i, its hold counter shall load HOLD at the same edge; otherwise a nonzero counter decrements by 1 every clock, independent of en and j/k.
REQ-020 With HOLD=H>0, a channel that transitions at edge t shall ignore j/k at edges t+1..t+H and be eligible again at edge t+H+1.
REQ-021 rise[i]/fall[i] shall assert for exactly one cycle after the edge producing the matching transition and deassert at the next edge; never both high.
REQ-022 Channels shall be fully independent; simultaneous transitions on any subset of channels shall all take effect at the same edge.
REQ-023 en=0 shall not freeze hold counters (lockout continues expiring).
REQ-024 j/k values on a locked channel shall be discarded, not queued.

Reset
REQ-025 reset=1 shall immediately, without a clock, force all channels OFF: out=0, rise=0, fall=0, hold counters=0, locked=0, on_count=0.
REQ-026 reset asserted mid-lockout or coincident with a transition shall win; first eligible edge is the first rising edge with reset=0.
REQ-027 No state shall depend on input values sampled while reset=1.

Verification (N=4, HOLD=2, MODE 0 unless stated)
REQ-028 Assert reset between edges -> out=0000, locked=0000, on_count=0 before next edge; release, j=0001,en=1, one edge -> out=0001, rise=0001, locked=0001, on_count=1.
REQ-029 Channel 0 ON, k=0001 held from next edge -> out stays 0001 for 2 edges (locked), goes 0000 at third edge with fall=0001 for one cycle.
REQ-030 All OFF, j=k=1111, en=1, one edge -> out=1111; after lockout expiry, one more edge with j=k=1111 -> out=0000, fall=1111, on_count=0.
REQ-031 MODE 1, all ON, j=k=1111 -> out stays 1111, no rise/fall pulses, locked stays 0000; then j=0000,k=0101 -> out=1010, on_count=2.
REQ-032 en=0 with j=1111 for 5 edges -> out unchanged, no pulses; channel locked at en drop reads locked=0 after 2 edges.
REQ-033 HOLD=0 build: alternating j and k on channel 2 every cycle -> out[2] toggles every edge, locked=0000 throughout.
